// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master = producer/consumer side, slave = adder side.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, sub,
    output out_ready,
    input  in_ready, out_valid, sum,
    input  carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub,
    input  out_ready,
    output in_ready, out_valid, sum,
    output carry_out, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// Add/sub with the carry chain cut into STAGES slices,
// one register per slice, valid/ready on both ends.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int S = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cq;
  logic [WIDTH-1:0]  aq [STAGES];
  logic [WIDTH-1:0]  bq [STAGES];
  logic [WIDTH-1:0]  rq [STAGES];

  // Whole pipe moves as one; bubbles are not squeezed out.
  assign adv          = !vld[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_d, b_d, r_d, r_n;
    logic [WIDTH-1:0] a_r, b_r, r_r;
    logic             c_d, v_d, v_r, c_r;
    logic [S:0]       part;

    if (k == 0) begin : g_in
      assign a_d = bus.a;
      assign b_d = bus.sub ? ~bus.b : bus.b;
      assign c_d = bus.sub || bus.carry_in;
      assign r_d = '0;
      assign v_d = bus.in_valid;
    end else begin : g_mid
      assign a_d = aq[k-1];
      assign b_d = bq[k-1];
      assign c_d = cq[k-1];
      assign r_d = rq[k-1];
      assign v_d = vld[k-1];
    end

    assign part = {1'b0, a_d[k*S +: S]}
                + {1'b0, b_d[k*S +: S]}
                + {{S{1'b0}}, c_d};

    always_comb begin
      r_n            = r_d;
      r_n[k*S +: S]  = part[S-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        a_r <= '0;
        b_r <= '0;
        r_r <= '0;
      end else if (adv) begin
        v_r <= v_d;
        if (v_d) begin
          c_r <= part[S];
          a_r <= a_d;
          b_r <= b_d;
          r_r <= r_n;
        end
      end
    end

    assign vld[k] = v_r;
    assign cq[k]  = c_r;
    assign aq[k]  = a_r;
    assign bq[k]  = b_r;
    assign rq[k]  = r_r;
  end

  assign bus.out_valid = vld[STAGES-1];
  assign bus.sum       = rq[STAGES-1];
  assign bus.carry_out = cq[STAGES-1];
  assign bus.overflow  =
    (aq[STAGES-1][WIDTH-1] == bq[STAGES-1][WIDTH-1]) &&
    (rq[STAGES-1][WIDTH-1] != aq[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 8/2 and 1/1 configurations
// against a signed/unsigned arithmetic reference.
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipelined_adder_if #(.WIDTH(W)) bus ();
  pipelined_adder_if #(.WIDTH(1)) bus1 ();

  pipelined_adder #(.WIDTH(W), .STAGES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipelined_adder #(.WIDTH(1), .STAGES(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    int s;
    int co;
    int ov;
    int t;
  } exp_t;

  function automatic exp_t model(
    input int     w,
    input longint a,
    input longint b,
    input int     cin,
    input int     sub,
    input int     t
  );
    exp_t   m;
    longint mask, half, full, sa, sb, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    if (sub != 0) full = a + ((~b) & mask) + 1;
    else          full = a + b + cin;
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    sr = (sub != 0) ? sa - sb : sa + sb + cin;
    m.s  = int'(full & mask);
    m.co = int'((full >> w) & 1);
    m.ov = (sr >= half || sr < -half) ? 1 : 0;
    m.t  = t;
    return m;
  endfunction

  task automatic put(
    input logic v, input int a, input int b,
    input logic cin, input logic sub
  );
    bus.in_valid = v;
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.carry_in = cin;
    bus.sub      = sub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    put(1'b0, 0, 0, 1'b0, 1'b0);
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = 1'b0;
    bus1.b         = 1'b0;
    bus1.carry_in  = 1'b0;
    bus1.sub       = 1'b0;
    bus1.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b want=0", bus.out_valid);
    end
    if (bus.sum !== 8'h00) begin
      bad++;
      $display("FAIL rst_sum got=%h want=00", bus.sum);
    end
    if (bus.carry_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_co got=%b want=0", bus.carry_out);
    end
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL rst_ov got=%b want=0", bus.overflow);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready got=%b want=1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_directed();
    int ta   [4] = '{'hFF, 'h7F, 'h05, 'h80};
    int tb_  [4] = '{'h01, 'h01, 'h07, 'h01};
    int tsub [4] = '{0, 0, 1, 1};
    int ts   [4] = '{'h00, 'h80, 'hFE, 'h7F};
    int tco  [4] = '{1, 0, 0, 1};
    int tov  [4] = '{0, 1, 0, 1};
    int t0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, ta[i], tb_[i], 1'b0, 1'(tsub[i]));
      t0 = cyc;
      tick();
      put(1'b0, 0, 0, 1'b0, 1'b0);
      while (!bus.out_valid && cyc - t0 < 10) tick();
      total++;
      if (bus.out_valid !== 1'b1 || cyc - t0 != N ||
          bus.sum !== 8'(ts[i]) ||
          bus.carry_out !== 1'(tco[i]) ||
          bus.overflow !== 1'(tov[i])) begin
        bad++;
        $display("FAIL directed%0d got v=%b lat=%0d s=%h c=%b o=%b want v=1 lat=%0d s=%h c=%0d o=%0d",
          i, bus.out_valid, cyc - t0, bus.sum, bus.carry_out,
          bus.overflow, N, ts[i], tco[i], tov[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) put(1'b1, c + 1, c + 1, 1'b0, 1'b0);
      else       put(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      if (c >= 2 && c < 6) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 8'(2 * (c - 1))) begin
          bad++;
          $display("FAIL b2b cyc%0d got v=%b s=%h want v=1 s=%h",
            c, bus.out_valid, bus.sum, 8'(2 * (c - 1)));
        end
      end else if (c >= 6) begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_dup cyc%0d got v=%b want 0", c, bus.out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int bi = 0;
    int got = 0;
    int exp_v [3] = '{2, 4, 6};
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = (c == 0 || c >= 8);
      if (bi < 3) put(1'b1, bi + 1, bi + 1, 1'b0, 1'b0);
      else        put(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      total++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        bad++;
        $display("FAIL bp_in_ready cyc%0d got=%b want=%b", c,
          bus.in_ready, !bus.out_valid || bus.out_ready);
      end
      if (c >= 2 && c < 8) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 8'h02) begin
          bad++;
          $display("FAIL bp_hold cyc%0d got v=%b s=%h want v=1 s=02",
            c, bus.out_valid, bus.sum);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (got >= 3) begin
          bad++;
          $display("FAIL bp_extra got s=%h want none", bus.sum);
        end else if (bus.sum !== 8'(exp_v[got])) begin
          bad++;
          $display("FAIL bp_order got s=%h want %h",
            bus.sum, 8'(exp_v[got]));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) bi++;
      tick();
    end
    total++;
    if (got != 3 || bi != 3) begin
      bad++;
      $display("FAIL bp_count got out=%0d in=%0d want 3/3", got, bi);
    end
  endtask

  task automatic test_random(input bit bp, input int n);
    exp_t       q [$];
    exp_t       e;
    logic       hold;
    logic [W-1:0] hold_s;
    for (int c = 0; c < n + N + 4; c++) begin
      if (c < n)
        put(1'($urandom_range(0, 9) < 7),
            int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      else
        put(1'b0, 0, 0, 1'b0, 1'b0);
      if (c >= n || !bp) bus.out_ready = 1'b1;
      else bus.out_ready = 1'($urandom_range(0, 9) < 6);
      #1;
      total++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        bad++;
        $display("FAIL rnd_in_ready got=%b want=%b", bus.in_ready,
          !bus.out_valid || bus.out_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rnd_spurious got s=%h want no beat", bus.sum);
        end else begin
          e = q.pop_front();
          if (bus.sum !== 8'(e.s) ||
              bus.carry_out !== 1'(e.co) ||
              bus.overflow !== 1'(e.ov) ||
              (!bp && cyc - e.t != N)) begin
            bad++;
            $display("FAIL rnd bp=%0d got s=%h c=%b o=%b lat=%0d want s=%h c=%0d o=%0d lat=%0d",
              bp, bus.sum, bus.carry_out, bus.overflow, cyc - e.t,
              8'(e.s), e.co, e.ov, N);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(W, longint'(bus.a), longint'(bus.b),
                          int'(bus.carry_in), int'(bus.sub), cyc));
      hold   = bus.out_valid && !bus.out_ready;
      hold_s = bus.sum;
      tick();
      if (hold) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.sum !== hold_s) begin
          bad++;
          $display("FAIL rnd_hold got v=%b s=%h want v=1 s=%h",
            bus.out_valid, bus.sum, hold_s);
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL rnd_lost got left=%0d want 0", q.size());
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      put(1'b1, 'hFF, 'hFF, 1'b1, 1'b0);
      tick();
    end
    put(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 8'hFF) begin
      bad++;
      $display("FAIL mrst_pre got v=%b s=%h want v=1 s=ff",
        bus.out_valid, bus.sum);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 8'h00 ||
        bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL mrst_async got v=%b s=%h c=%b o=%b want 0/00/0/0",
        bus.out_valid, bus.sum, bus.carry_out, bus.overflow);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mrst_in_ready got=%b want=1", bus.in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mrst_stale cyc%0d got v=%b want 0",
          c, bus.out_valid);
      end
    end
  endtask

  task automatic test_unit1();
    exp_t e;
    bus1.out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      bus1.in_valid = (i < 16);
      bus1.a        = 1'(i);
      bus1.b        = 1'(i >> 1);
      bus1.carry_in = 1'(i >> 2);
      bus1.sub      = 1'(i >> 3);
      #1;
      if (i > 0) begin
        e = model(1, longint'((i - 1) & 1),
                  longint'(((i - 1) >> 1) & 1),
                  ((i - 1) >> 2) & 1, ((i - 1) >> 3) & 1, 0);
        total++;
        if (bus1.out_valid !== 1'b1 ||
            bus1.sum !== 1'(e.s) ||
            bus1.carry_out !== 1'(e.co) ||
            bus1.overflow !== 1'(e.ov)) begin
          bad++;
          $display("FAIL w1 combo%0d got v=%b s=%b c=%b o=%b want v=1 s=%0d c=%0d o=%0d",
            i - 1, bus1.out_valid, bus1.sum, bus1.carry_out,
            bus1.overflow, e.s, e.co, e.ov);
        end
      end
      tick();
    end
    bus1.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random(1'b0, 200);
    test_random(1'b1, 300);
    test_mid_reset();
    test_unit1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the single-bit registered full adder.
- Adds or subtracts two WIDTH-bit operands plus carry-in.
- Splits the carry chain into STAGES equal slices, one pipeline register per slice.
- Uses a valid/ready handshake on both sides.
- Sits between datapath producers and consumers that need a timing-closed adder with backpressure.

Parameters:
- WIDTH, 8: operand/result width in bits; must be >= 1.
- STAGES, 2: pipeline depth and number of carry-chain slices; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0; slice width S = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts the beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- carry_in  in  1  carry into bit 0 (add mode only)
- sub  in  1  0 = a+b+carry_in; 1 = a-b (a + ~b + 1), carry_in ignored
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- carry_out  out  1  carry out of MSB (in sub mode, 1 = no borrow)
- overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset (async, any time): all stage valid bits = 0, all slice/carry/operand-skew registers = 0. Outputs: out_valid=0, sum=0, carry_out=0, overflow=0. in_ready=1 once rst deasserts.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational; there is no in_valid->in_ready path.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Operand preparation at stage 0:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : carry_in.
- Stage k (0..STAGES-1), on adv:
  - Adds slice k of a and b_eff plus the carry registered by stage k-1 (c0 for k=0).
  - Registers the S-bit partial sum and the slice carry.
  - Slices above k travel unmodified in skew registers.
  - Lower result slices travel forward already computed.
- Valid propagation, on adv:
  - vld[0] <= in_valid.
  - vld[k] <= vld[k-1].
  - out_valid = vld[STAGES-1].
- Stall (!adv): every register holds. Bubbles are not compressed; an empty stage still waits when the output stalls.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles later if no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Final outputs:
  - sum = concatenated slices.
  - carry_out = carry from the top slice.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), computed from operand MSBs carried in skew registers.
- Arithmetic: modulo 2^WIDTH. No saturation.
- Datapath registers update only while the corresponding vld bit is set. Outputs are held stable while out_valid && !out_ready.
- Boundary cases:
  - Simultaneous output pop and input push with a full pipeline: allowed, no bubble.
  - rst mid-flight: all in-flight beats are dropped, and no out_valid is produced for them.
  - STAGES=1: single register stage, latency 1.
  - WIDTH=STAGES=1: behaves as a registered full adder.
- Unused inputs: a, b, carry_in and sub are don't-care when in_valid=0 and have no effect on state.

Test Plan:
1. WIDTH=8, STAGES=2, out_ready=1: a=0xFF, b=0x01, cin=0, sub=0 -> 2 cycles later out_valid=1, sum=0x00, carry_out=1, overflow=0.
2. a=0x7F, b=0x01, cin=0 -> sum=0x80, carry_out=0, overflow=1. Then sub=1, a=0x05, b=0x07 -> sum=0xFE, carry_out=0, overflow=0. Then sub=1, a=0x80, b=0x01 -> sum=0x7F, overflow=1.
3. Back-to-back 4 beats (1+1, 2+2, 3+3, 4+4), out_ready=1 -> results 0x02, 0x04, 0x06, 0x08 on 4 consecutive cycles starting cycle 2.
4. Backpressure: out_ready=0 from cycle 1 while pushing 3 beats -> in_ready drops once out_valid=1. Result 0x02 held stable. Raising out_ready drains 0x02, 0x04, 0x06 in order with no loss or duplication.
5. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0, sum=0, carry_out=0 immediately (async). No stale beat emerges afterwards. in_ready=1 after release.
6. WIDTH=1, STAGES=1: a=1, b=1, cin=0 -> next cycle sum=0, carry_out=1. Also a=1, b=0, cin=1 -> sum=0, carry_out=1. Also a=0, b=0, cin=1 -> sum=1, carry_out=0.
